// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: I-cache miss handler. When a miss occurs it streams one block
// from pipelined main memory into the data array. It then writes the tag, and it
// holds fetch stalled until the fill is done.
// Optional feature: define ICACHE_FILL_PERF_EN to add the saturating miss_count output.
module icache_fill_ctrl #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [15:0]       cache_data,
  output logic              write_tag_array,
`ifdef ICACHE_FILL_PERF_EN
  output logic [15:0]       miss_count,
`endif
  output logic [ADDR_W-1:0] block_base
);

  // Block offset bits cover the word index plus the byte-within-word bit.
  localparam int BLK_OFF_W = CNT_W + 1;
  // Counters carry one extra bit so "all words requested" is representable.
  localparam logic [CNT_W:0] BLOCK_WORDS = (CNT_W+1)'(WORDS_PER_BLOCK);
  localparam logic [CNT_W:0] BLOCK_LAST  = (CNT_W+1)'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W:0]    req_cnt_q, req_cnt_d;
  logic [CNT_W:0]    rcv_cnt_q, rcv_cnt_d;
  logic [ADDR_W-1:0] block_base_q, block_base_d;
  logic [ADDR_W-1:0] cache_word_addr_q, cache_word_addr_d;
  logic [15:0]       cache_data_q, cache_data_d;
  logic              write_data_q, write_data_d;

  // The offset bits of the miss address are deliberately dropped when the block base is formed.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[BLK_OFF_W-1:0];

  // Next-state logic covers the request counter, the receive counter and the address bookkeeping.
  // It also drives the combinational request and tag strobes.
  always_comb begin
    state_d           = state_q;
    req_cnt_d         = req_cnt_q;
    rcv_cnt_d         = rcv_cnt_q;
    block_base_d      = block_base_q;
    cache_word_addr_d = cache_word_addr_q;
    cache_data_d      = cache_data_q;
    write_data_d      = 1'b0;
    mem_req           = 1'b0;
    memory_address    = '0;
    write_tag_array   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          block_base_d = {miss_address[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
          req_cnt_d    = '0;
          rcv_cnt_d    = '0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (req_cnt_q < BLOCK_WORDS) begin
          mem_req        = 1'b1;
          memory_address = block_base_q + ADDR_W'({req_cnt_q[CNT_W-1:0], 1'b0});
          req_cnt_d      = req_cnt_q + 1'b1;
        end
        if (memory_data_valid) begin
          cache_data_d      = memory_data;
          cache_word_addr_d = block_base_q + ADDR_W'({rcv_cnt_q[CNT_W-1:0], 1'b0});
          write_data_d      = 1'b1;
          rcv_cnt_d         = rcv_cnt_q + 1'b1;
          if (rcv_cnt_q == BLOCK_LAST) begin
            state_d = TAG;
          end
        end
      end
      TAG: begin
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset abandons any partial fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      req_cnt_q         <= '0;
      rcv_cnt_q         <= '0;
      block_base_q      <= '0;
      cache_word_addr_q <= '0;
      cache_data_q      <= '0;
      write_data_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      req_cnt_q         <= req_cnt_d;
      rcv_cnt_q         <= rcv_cnt_d;
      block_base_q      <= block_base_d;
      cache_word_addr_q <= cache_word_addr_d;
      cache_data_q      <= cache_data_d;
      write_data_q      <= write_data_d;
    end
  end

  assign fsm_busy         = (state_q != IDLE) | miss_detected;
  assign write_data_array = write_data_q;
  assign cache_word_addr  = cache_word_addr_q;
  assign cache_data       = cache_data_q;
  assign block_base       = block_base_q;

`ifdef ICACHE_FILL_PERF_EN
  logic [15:0] miss_count_q, miss_count_d;

  // Count each fill start, saturating at the maximum value instead of wrapping.
  always_comb begin
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && miss_detected && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  // Miss counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign miss_count = miss_count_q;
`endif

endmodule
